// File: rtl/seven_seg_pkg.sv
// Shared constants, state encoding and value arithmetic for the seven-segment capture monitor.
package seven_seg_pkg;

  localparam logic [6:0] D0        = 7'b1000000;
  localparam logic [6:0] D1        = 7'b1111001;
  localparam logic [6:0] D2        = 7'b0100100;
  localparam logic [6:0] D3        = 7'b0110000;
  localparam logic [6:0] D4        = 7'b0011001;
  localparam logic [6:0] D5        = 7'b0010010;
  localparam logic [6:0] D6        = 7'b0000010;
  localparam logic [6:0] D7        = 7'b1011000;
  localparam logic [6:0] D8        = 7'b0000000;
  localparam logic [6:0] D9        = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_e;

  // tens*10 built from shifts so no multiplier is inferred; max result 99 fits 7 bits
  function automatic logic [6:0] pair_to_value(input logic [3:0] tens, input logic [3:0] ones);
    logic [6:0] t7;
    t7 = {3'b000, tens};
    return (t7 << 3) + (t7 << 1) + {3'b000, ones};
  endfunction

endpackage

// File: rtl/seg_to_digit.sv
// Combinational decode of one active-low segment pattern into a BCD digit plus legality flag.
module seg_to_digit
  import seven_seg_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] digit,
  output logic       legal
);

  // pattern lookup; anything outside the ten glyphs is reported illegal
  always_comb begin
    digit = 4'd0;
    legal = 1'b1;
    case (seg)
      D0:      digit = 4'd0;
      D1:      digit = 4'd1;
      D2:      digit = 4'd2;
      D3:      digit = 4'd3;
      D4:      digit = 4'd4;
      D5:      digit = 4'd5;
      D6:      digit = 4'd6;
      D7:      digit = 4'd7;
      D8:      digit = 4'd8;
      D9:      digit = 4'd9;
      default: begin
        digit = 4'd0;
        legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/seven_seg_capture.sv
// Samples a tens/ones segment pair, waits for it to be stable for STABLE_CYCLES clocks,
// then reports the decoded 0..99 value (o_valid) or an illegal pattern (o_error).
module seven_seg_capture
  import seven_seg_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [6:0]  i_seven_ten,
  input  logic [6:0]  i_seven_one,
  output logic [31:0] o_value,
  output logic        o_valid,
  output logic        o_error,
  output logic        o_busy
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX    = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_ACCEPT = CW'(STABLE_CYCLES - 1);

  logic [13:0]   pair_s;
  logic [13:0]   sample_r;
  logic          match_s;
  logic          accept_s;
  logic [CW-1:0] cnt_r;
  state_e        state_r;
  logic [3:0]    ten_digit_s;
  logic [3:0]    one_digit_s;
  logic          ten_legal_s;
  logic          one_legal_s;

  // The incoming pair is the new sample; sample_r holds the previous one.
  // Accepting on the edge whose count would reach STABLE_CYCLES puts the
  // strobe in the cycle after edge E0+STABLE_CYCLES.
  always_comb begin
    pair_s   = {i_seven_ten, i_seven_one};
    match_s  = (pair_s == sample_r);
    accept_s = 1'b0;
    if ((state_r == SETTLE) && match_s && ((cnt_r == CNT_ACCEPT) || (cnt_r == CNT_MAX))) begin
      accept_s = 1'b1;
    end else begin
      accept_s = 1'b0;
    end
  end

  seg_to_digit u_ten (
    .seg   (sample_r[13:7]),
    .digit (ten_digit_s),
    .legal (ten_legal_s)
  );

  seg_to_digit u_one (
    .seg   (sample_r[6:0]),
    .digit (one_digit_s),
    .legal (one_legal_s)
  );

  // Sample register, stability counter, state machine and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sample_r <= {SEG_BLANK, SEG_BLANK};
      cnt_r    <= '0;
      state_r  <= IDLE;
      o_value  <= 32'd0;
      o_valid  <= 1'b0;
      o_error  <= 1'b0;
      o_busy   <= 1'b0;
    end else begin
      sample_r <= pair_s;
      o_valid  <= 1'b0;
      o_error  <= 1'b0;

      if (!match_s) begin
        cnt_r <= '0;
      end else if (cnt_r != CNT_MAX) begin
        cnt_r <= cnt_r + CW'(1);
      end

      case (state_r)
        IDLE: begin
          state_r <= SETTLE;
          o_busy  <= 1'b1;
        end
        SETTLE: begin
          if (accept_s) begin
            state_r <= HOLD;
            o_busy  <= 1'b0;
            if (ten_legal_s && one_legal_s) begin
              o_value <= {25'd0, pair_to_value(ten_digit_s, one_digit_s)};
              o_valid <= 1'b1;
            end else begin
              o_error <= 1'b1;
            end
          end else begin
            o_busy <= 1'b1;
          end
        end
        HOLD: begin
          if (!match_s) begin
            state_r <= SETTLE;
            o_busy  <= 1'b1;
          end else begin
            o_busy <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seven_seg_capture.sv
// Directed bench for seven_seg_capture: table-driven sweep of all legal pairs plus
// hand-written sequences for latency, glitch, illegal-pattern and reset corners.
module tb_seven_seg_capture;

  typedef struct {
    logic [6:0]  ten;
    logic [6:0]  one;
    logic [31:0] exp_value;
  } vec_t;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [6:0]  ten4, one4, ten1, one1;
  logic [31:0] value4, value1;
  logic        valid4, error4, busy4, valid1, error1, busy1;

  logic [6:0]  seg_lut [10];
  vec_t        vec [100];
  int          n_chk = 0;
  int          n_fail = 0;
  bit          saw98 = 1'b0;

  seven_seg_capture #(.STABLE_CYCLES(4)) dut4 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_seven_ten(ten4), .i_seven_one(one4),
    .o_value(value4), .o_valid(valid4), .o_error(error4), .o_busy(busy4)
  );

  seven_seg_capture #(.STABLE_CYCLES(1)) dut1 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_seven_ten(ten1), .i_seven_one(one1),
    .o_value(value1), .o_valid(valid1), .o_error(error1), .o_busy(busy1)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // runs n cycles on the STABLE_CYCLES=4 instance, tallying strobes
  task automatic run_window(input int n, output int nv, output int ne, output logic [31:0] last_v);
    nv = 0;
    ne = 0;
    last_v = 32'hFFFF_FFFF;
    for (int k = 0; k < n; k++) begin
      tick();
      if (valid4) begin
        nv++;
        last_v = value4;
      end
      if (error4) ne++;
      if (value4 == 32'd98) saw98 = 1'b1;
    end
  endtask

  initial begin
    int nv, ne;
    logic [31:0] lv;

    seg_lut[0] = 7'b1000000; seg_lut[1] = 7'b1111001; seg_lut[2] = 7'b0100100;
    seg_lut[3] = 7'b0110000; seg_lut[4] = 7'b0011001; seg_lut[5] = 7'b0010010;
    seg_lut[6] = 7'b0000010; seg_lut[7] = 7'b1011000; seg_lut[8] = 7'b0000000;
    seg_lut[9] = 7'b0010000;
    for (int t = 0; t < 10; t++) begin
      for (int o = 0; o < 10; o++) begin
        vec[t*10+o].ten       = seg_lut[t];
        vec[t*10+o].one       = seg_lut[o];
        vec[t*10+o].exp_value = 32'(t*10 + o);
      end
    end

    // reset state, with D4/D2 already presented
    ten4 = seg_lut[4]; one4 = seg_lut[2];
    ten1 = 7'b1111111; one1 = 7'b1111111;
    #12;
    chk("reset_value", value4, 32'd0);
    chk("reset_valid", {31'd0, valid4}, 32'd0);
    chk("reset_error", {31'd0, error4}, 32'd0);
    chk("reset_busy", {31'd0, busy4}, 32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // D4/D2: busy for 4 cycles after E0, strobe after E0+4
    tick();
    for (int k = 0; k < 3; k++) begin
      chk("d42_busy", {31'd0, busy4}, 32'd1);
      chk("d42_novalid", {31'd0, valid4}, 32'd0);
      tick();
    end
    chk("d42_busy_last", {31'd0, busy4}, 32'd1);
    tick();
    chk("d42_valid", {31'd0, valid4}, 32'd1);
    chk("d42_value", value4, 32'd42);
    chk("d42_busy_accept", {31'd0, busy4}, 32'd0);
    tick();
    chk("d42_single_strobe", {31'd0, valid4}, 32'd0);

    // D9/D9 accepted, then a 2-cycle D8 glitch on ones
    ten4 = seg_lut[9]; one4 = seg_lut[9];
    run_window(5, nv, ne, lv);
    chk("d99_count", 32'(nv), 32'd1);
    chk("d99_value", lv, 32'd99);
    one4 = seg_lut[8];
    run_window(2, nv, ne, lv);
    chk("glitch_no_strobe", 32'(nv), 32'd0);
    one4 = seg_lut[9];
    run_window(7, nv, ne, lv);
    chk("reaccept_count", 32'(nv), 32'd1);
    chk("reaccept_value", lv, 32'd99);
    chk("reaccept_noerr", 32'(ne), 32'd0);
    chk("never_98", {31'd0, saw98}, 32'd0);

    // illegal tens pattern
    ten4 = 7'b1111111; one4 = seg_lut[3];
    run_window(7, nv, ne, lv);
    chk("illegal_err_count", 32'(ne), 32'd1);
    chk("illegal_valid_count", 32'(nv), 32'd0);
    chk("illegal_value_kept", value4, 32'd99);

    // sweep of every legal pair, 6 cycles each
    for (int i = 0; i < 100; i++) begin
      ten4 = vec[i].ten;
      one4 = vec[i].one;
      run_window(6, nv, ne, lv);
      chk($sformatf("sweep%0d_count", i), 32'(nv), 32'd1);
      chk($sformatf("sweep%0d_value", i), lv, vec[i].exp_value);
      chk($sformatf("sweep%0d_noerr", i), 32'(ne), 32'd0);
    end

    // same value held after a change to a new pair and a pair changing on the acceptance edge
    ten4 = seg_lut[1]; one4 = seg_lut[2];
    run_window(4, nv, ne, lv);
    one4 = seg_lut[3];
    run_window(1, nv, ne, lv);
    chk("late_change_suppressed", 32'(nv), 32'd0);
    run_window(4, nv, ne, lv);
    chk("late_change_count", 32'(nv), 32'd1);
    chk("late_change_value", lv, 32'd13);

    // reset asserted two cycles into SETTLE on D7/D0
    ten4 = seg_lut[7]; one4 = seg_lut[0];
    tick();
    tick();
    chk("pre_reset_busy", {31'd0, busy4}, 32'd1);
    i_rst_n = 1'b0;
    #1;
    chk("async_value", value4, 32'd0);
    chk("async_valid", {31'd0, valid4}, 32'd0);
    chk("async_error", {31'd0, error4}, 32'd0);
    chk("async_busy", {31'd0, busy4}, 32'd0);
    tick();
    tick();
    i_rst_n = 1'b1;
    run_window(6, nv, ne, lv);
    chk("post_reset_count", 32'(nv), 32'd1);
    chk("post_reset_value", value4, 32'd70);
    chk("post_reset_idle_busy", {31'd0, busy4}, 32'd0);

    // STABLE_CYCLES = 1: pair changes every 2 cycles, each reported one cycle after capture
    for (int i = 3; i < 100; i += 17) begin
      ten1 = vec[i].ten;
      one1 = vec[i].one;
      tick();
      chk($sformatf("s1_%0d_busy", i), {31'd0, busy1}, 32'd1);
      chk($sformatf("s1_%0d_early", i), {31'd0, valid1}, 32'd0);
      tick();
      chk($sformatf("s1_%0d_valid", i), {31'd0, valid1}, 32'd1);
      chk($sformatf("s1_%0d_value", i), value1, vec[i].exp_value);
      chk($sformatf("s1_%0d_noerr", i), {31'd0, error1}, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
